mips_16: RTL and testbench
==========================

Name: mips_16

Overview:
- 16-bit single-cycle MIPS-style processor: one instruction fetched, decoded, executed and retired per clk rising edge.
- Contains PC, instruction ROM, 8x16 register file, ALU, data RAM and control decode.
- Exposes PC, current instruction, ALU result and registers r1–r3 for top-level observation and debug.

Parameters:
- IMEM_DEPTH, 256, instruction ROM words; indexed by pc_out[7:0].
- DMEM_DEPTH, 64, data RAM words; indexed by address[5:0].

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset; keeps the codebase name "reset"; 0 = in reset.
- pc_out  output  16  current PC, word address.
- instruction  output  16  combinational ROM word at pc_out.
- alu_result  output  16  combinational ALU output for the current instruction.
- reg1  output  16  register r1 contents.
- reg2  output  16  register r2 contents.
- reg3  output  16  register r3 contents.

Behaviour:
- Reset (reset=0, asynchronous): PC=0; r0–r7=0; data RAM=0. Consequently pc_out=0, reg1–reg3=0, instruction=ROM[0].
- Encoding: op[15:12], rs[11:9], rt[8:6], rd[5:3], funct[2:0]; imm6[5:0] sign-extended to 16 bits; addr12[11:0].
- Opcodes:
  - 0000 R-type: rd <= rs OP rt.
  - 0001 addi: rt <= rs + imm.
  - 0010 slti: rt <= (signed rs < imm) ? 1 : 0.
  - 0100 lw: rt <= DMEM[rs + imm].
  - 0101 sw: DMEM[rs + imm] <= rt.
  - 0110 beq; 0111 bne: taken target = PC+1+imm.
  - 1000 j: PC <= {PC[15:12], addr12}.
  - 1001 jal: r7 <= PC+1, then jumps as j.
  - Any other opcode: NOP (PC+1, no writes).
- R-type funct: 000 add, 001 sub, 010 and, 011 or, 100 xor, 101 slt (signed), 110 sll, 111 srl. Shift amount = rt[3:0].
- Arithmetic: 16-bit two's complement, wrap-around, no overflow trap.
- Branch compare uses the ALU subtract; alu_result shows rs−rt.
- PC default PC+1, wraps 0xFFFF→0x0000.
- r0 hardwired 0: reads return 0, writes are ignored.
- Register file: 2 combinational read ports, 1 write port on the rising edge. A read of the register written in the same cycle returns the old value.
- Data RAM address = alu_result[5:0]. Combinational read; write on the rising edge.
- ROM: words beyond the programmed image read 0x0000 (add r0,r0,r0 = NOP).
- Default ROM image:
  - 0:1045 addi r1,r0,5
  - 1:1083 addi r2,r0,3
  - 2:0298 add r3,r1,r2
  - 3:0299 sub r3,r1,r2
  - 4:50C0 sw r3,0(r0)
  - 5:4080 lw r2,0(r0)
  - 6:64C1 beq r2,r3,+1
  - 7:1041 addi r1,r0,1
  - 8:8008 j 8
- Reset asserted mid-program: all state clears immediately; execution restarts at PC 0 on the first rising edge after deassertion.

Decomposition:
- Package mips16_pkg: opcode and funct localparams, field-position constants, ALU-op enum typedef.
- Sub-module mips16_regfile: 8x16 register file, r0 hardwired, async active-low clear.
- Everything else stays in mips_16.

Test Plan:
- Reset held 100 ns with 20 ns clk → pc_out=0, instruction=1045, reg1=reg2=reg3=0.
- Release reset, 3 edges → reg1=5, reg2=3, reg3=8; alu_result=8 while PC=2.
- Edge 4 → reg3=2; edges 5–6 (sw/lw) → reg2=2.
- PC=6 beq taken → next pc_out=8; reg1 stays 5 (PC 7 skipped).
- PC=8 j 8 → pc_out remains 8 on every following edge; all registers stable.
- Assert reset mid-run → pc_out and reg1–3 drop to 0 without waiting for clk; after release the program replays identically.

Source files
------------

// File: rtl/mips16_pkg.sv
// mips16_pkg: shared definitions for the mips_16 processor.
//   - instruction field positions
//   - opcode and R-type funct encodings
//   - ALU operation enum and the funct-to-ALU-op mapping
//   - immediate sign-extension helper
package mips16_pkg;

    // Instruction field LSB positions
    localparam int unsigned OP_LSB    = 12;  // op[15:12]
    localparam int unsigned RS_LSB    = 9;   // rs[11:9]
    localparam int unsigned RT_LSB    = 6;   // rt[8:6]
    localparam int unsigned RD_LSB    = 3;   // rd[5:3]
    localparam int unsigned FUNCT_LSB = 0;   // funct[2:0]

    // Opcodes
    localparam logic [3:0] OP_RTYPE = 4'b0000;
    localparam logic [3:0] OP_ADDI  = 4'b0001;
    localparam logic [3:0] OP_SLTI  = 4'b0010;
    localparam logic [3:0] OP_LW    = 4'b0100;
    localparam logic [3:0] OP_SW    = 4'b0101;
    localparam logic [3:0] OP_BEQ   = 4'b0110;
    localparam logic [3:0] OP_BNE   = 4'b0111;
    localparam logic [3:0] OP_J     = 4'b1000;
    localparam logic [3:0] OP_JAL   = 4'b1001;

    // R-type funct codes
    localparam logic [2:0] FN_ADD = 3'b000;
    localparam logic [2:0] FN_SUB = 3'b001;
    localparam logic [2:0] FN_AND = 3'b010;
    localparam logic [2:0] FN_OR  = 3'b011;
    localparam logic [2:0] FN_XOR = 3'b100;
    localparam logic [2:0] FN_SLT = 3'b101;
    localparam logic [2:0] FN_SLL = 3'b110;
    localparam logic [2:0] FN_SRL = 3'b111;

    // Link register written by jal
    localparam logic [2:0] LINK_REG = 3'd7;

    typedef enum logic [2:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_XOR,
        ALU_SLT,
        ALU_SLL,
        ALU_SRL
    } alu_op_e;

    function automatic alu_op_e funct_to_alu(input logic [2:0] funct);
        alu_op_e op;
        case (funct)
            FN_ADD:  op = ALU_ADD;
            FN_SUB:  op = ALU_SUB;
            FN_AND:  op = ALU_AND;
            FN_OR:   op = ALU_OR;
            FN_XOR:  op = ALU_XOR;
            FN_SLT:  op = ALU_SLT;
            FN_SLL:  op = ALU_SLL;
            default: op = ALU_SRL;
        endcase
        return op;
    endfunction

    function automatic logic [15:0] sext6(input logic [5:0] v);
        return {{10{v[5]}}, v};
    endfunction

endpackage

// File: rtl/mips_16_if.sv
// mips_16_if: register-file access bundle between the mips_16 core and
// mips16_regfile.
//   master (core)   : drives read addresses and the write port,
//                     receives read data and r1..r3 debug taps
//   slave (regfile) : the reverse
interface mips_16_if;
    logic [2:0]  ra1;   // read port 1 address (rs)
    logic [2:0]  ra2;   // read port 2 address (rt)
    logic [15:0] rd1;   // read port 1 data
    logic [15:0] rd2;   // read port 2 data
    logic        we;    // write enable
    logic [2:0]  wa;    // write address
    logic [15:0] wd;    // write data
    logic [15:0] r1;    // debug tap r1
    logic [15:0] r2;    // debug tap r2
    logic [15:0] r3;    // debug tap r3

    modport master (
        output ra1, ra2, we, wa, wd,
        input  rd1, rd2, r1, r2, r3
    );

    modport slave (
        input  ra1, ra2, we, wa, wd,
        output rd1, rd2, r1, r2, r3
    );
endinterface

// File: rtl/mips16_regfile.sv
// mips16_regfile: 8x16 register file.
//   clk   : rising-edge write clock
//   rst_n : asynchronous active-low clear of all registers
//   rf    : mips_16_if.slave - two combinational read ports, one write port,
//           r1..r3 debug taps
// r0 reads as zero and ignores writes. Reads see the pre-edge value even when
// the same register is being written this cycle.
module mips16_regfile (
    input  logic         clk,
    input  logic         rst_n,
    mips_16_if.slave     rf
);

    logic [15:0] regs [8];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < 8; i++) begin
                regs[i] <= '0;
            end
        end else if (rf.we && (rf.wa != '0)) begin
            regs[rf.wa] <= rf.wd;
        end
    end

    assign rf.rd1 = (rf.ra1 == '0) ? '0 : regs[rf.ra1];
    assign rf.rd2 = (rf.ra2 == '0) ? '0 : regs[rf.ra2];
    assign rf.r1  = regs[1];
    assign rf.r2  = regs[2];
    assign rf.r3  = regs[3];

endmodule

// File: rtl/mips_16.sv
// mips_16: 16-bit single-cycle MIPS-style processor. One instruction is
// fetched, decoded, executed and retired on every rising clk edge.
//   clk         : system clock
//   reset       : asynchronous, active-low; clears PC, registers, data RAM
//   pc_out      : current PC (word address)
//   instruction : ROM word at pc_out
//   alu_result  : ALU output for the current instruction
//   reg1..reg3  : register r1..r3 contents
module mips_16
    import mips16_pkg::*;
#(
    parameter int unsigned IMEM_DEPTH = 256,
    parameter int unsigned DMEM_DEPTH = 64
) (
    input  logic        clk,
    input  logic        reset,
    output logic [15:0] pc_out,
    output logic [15:0] instruction,
    output logic [15:0] alu_result,
    output logic [15:0] reg1,
    output logic [15:0] reg2,
    output logic [15:0] reg3
);

    localparam int unsigned IA_W = $clog2(IMEM_DEPTH);
    localparam int unsigned DA_W = $clog2(DMEM_DEPTH);

    logic [15:0] pc;
    logic [15:0] pc_next;
    logic [15:0] pc_plus1;

    logic [3:0]  op;
    logic [2:0]  rs, rt, rd, funct;
    logic [15:0] imm;

    logic [15:0] rs_val, rt_val;
    logic [15:0] alu_b;
    alu_op_e     alu_op;
    logic        alu_zero;

    logic [15:0]     dmem [DMEM_DEPTH];
    logic [DA_W-1:0] dmem_addr;
    logic [15:0]     ld_data;

    mips_16_if rf_if ();

    mips16_regfile u_regfile (
        .clk   (clk),
        .rst_n (reset),
        .rf    (rf_if)
    );

    // Instruction ROM; unprogrammed words read 0x0000 (add r0,r0,r0)
    always_comb begin
        instruction = '0;
        case (pc[IA_W-1:0])
            IA_W'(0): instruction = 16'h1045;  // addi r1,r0,5
            IA_W'(1): instruction = 16'h1083;  // addi r2,r0,3
            IA_W'(2): instruction = 16'h0298;  // add  r3,r1,r2
            IA_W'(3): instruction = 16'h0299;  // sub  r3,r1,r2
            IA_W'(4): instruction = 16'h50C0;  // sw   r3,0(r0)
            IA_W'(5): instruction = 16'h4080;  // lw   r2,0(r0)
            IA_W'(6): instruction = 16'h64C1;  // beq  r2,r3,+1
            IA_W'(7): instruction = 16'h1041;  // addi r1,r0,1
            IA_W'(8): instruction = 16'h8008;  // j    8
            default:  instruction = '0;
        endcase
    end

    // Field decode
    assign op    = instruction[OP_LSB +: 4];
    assign rs    = instruction[RS_LSB +: 3];
    assign rt    = instruction[RT_LSB +: 3];
    assign rd    = instruction[RD_LSB +: 3];
    assign funct = instruction[FUNCT_LSB +: 3];
    assign imm   = sext6(instruction[5:0]);

    assign rf_if.ra1 = rs;
    assign rf_if.ra2 = rt;
    assign rs_val    = rf_if.rd1;
    assign rt_val    = rf_if.rd2;

    // ALU operation and second operand select
    always_comb begin
        alu_op = ALU_ADD;
        alu_b  = rt_val;
        case (op)
            OP_RTYPE: alu_op = funct_to_alu(funct);
            OP_ADDI,
            OP_LW,
            OP_SW:    alu_b  = imm;
            OP_SLTI: begin
                alu_op = ALU_SLT;
                alu_b  = imm;
            end
            OP_BEQ,
            OP_BNE:   alu_op = ALU_SUB;
            default:  alu_op = ALU_ADD;
        endcase
    end

    always_comb begin
        alu_result = '0;
        case (alu_op)
            ALU_ADD: alu_result = rs_val + alu_b;
            ALU_SUB: alu_result = rs_val - alu_b;
            ALU_AND: alu_result = rs_val & alu_b;
            ALU_OR:  alu_result = rs_val | alu_b;
            ALU_XOR: alu_result = rs_val ^ alu_b;
            ALU_SLT: alu_result = {15'd0, ($signed(rs_val) < $signed(alu_b))};
            ALU_SLL: alu_result = rs_val << alu_b[3:0];
            ALU_SRL: alu_result = rs_val >> alu_b[3:0];
            default: alu_result = '0;
        endcase
    end

    assign alu_zero = (alu_result == '0);

    // Data RAM: combinational read, rising-edge write, async clear
    assign dmem_addr = alu_result[DA_W-1:0];
    assign ld_data   = dmem[dmem_addr];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < DMEM_DEPTH; i++) begin
                dmem[i] <= '0;
            end
        end else if (op == OP_SW) begin
            dmem[dmem_addr] <= rt_val;
        end
    end

    // Register write-back
    always_comb begin
        rf_if.we = 1'b0;
        rf_if.wa = rd;
        rf_if.wd = alu_result;
        case (op)
            OP_RTYPE: rf_if.we = 1'b1;
            OP_ADDI,
            OP_SLTI: begin
                rf_if.we = 1'b1;
                rf_if.wa = rt;
            end
            OP_LW: begin
                rf_if.we = 1'b1;
                rf_if.wa = rt;
                rf_if.wd = ld_data;
            end
            OP_JAL: begin
                rf_if.we = 1'b1;
                rf_if.wa = LINK_REG;
                rf_if.wd = pc_plus1;
            end
            default: rf_if.we = 1'b0;
        endcase
    end

    // Next PC
    assign pc_plus1 = pc + 16'd1;

    always_comb begin
        pc_next = pc_plus1;
        case (op)
            OP_BEQ: if (alu_zero)  pc_next = pc_plus1 + imm;
            OP_BNE: if (!alu_zero) pc_next = pc_plus1 + imm;
            OP_J,
            OP_JAL: pc_next = {pc[15:12], instruction[11:0]};
            default: pc_next = pc_plus1;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc <= '0;
        end else begin
            pc <= pc_next;
        end
    end

    assign pc_out = pc;
    assign reg1   = rf_if.r1;
    assign reg2   = rf_if.r2;
    assign reg3   = rf_if.r3;

endmodule

// File: tb/tb_mips_16.sv
// tb_mips_16: self-checking bench for mips_16. Checks the documented program
// trace against fixed expectations, and runs randomly timed reset/run
// sequences against an instruction-level model of the processor.
module tb_mips_16;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] pc_out, instruction, alu_result, reg1, reg2, reg3;

    int vectors     = 0;
    int miscompares = 0;

    always #10 clk = ~clk;

    mips_16 dut (
        .clk         (clk),
        .reset       (reset),
        .pc_out      (pc_out),
        .instruction (instruction),
        .alu_result  (alu_result),
        .reg1        (reg1),
        .reg2        (reg2),
        .reg3        (reg3)
    );

    // Observation bundle for the register debug taps
    mips_16_if obs_if ();
    assign obs_if.r1 = reg1;
    assign obs_if.r2 = reg2;
    assign obs_if.r3 = reg3;

    // ---------------- instruction-level reference model ----------------
    localparam logic [15:0] IMG [9] = '{
        16'h1045, 16'h1083, 16'h0298, 16'h0299, 16'h50C0,
        16'h4080, 16'h64C1, 16'h1041, 16'h8008
    };

    logic [15:0] m_pc;
    logic [15:0] m_r   [8];
    logic [15:0] m_mem [64];

    function automatic logic [15:0] rom_at(input logic [15:0] pc);
        if (pc[7:0] < 8'd9) return IMG[pc[3:0]];
        return 16'h0000;
    endfunction

    function automatic logic [15:0] sx(input logic [5:0] v);
        return {{10{v[5]}}, v};
    endfunction

    // Opcodes whose ALU output is architecturally defined
    function automatic bit alu_defined(input logic [3:0] op);
        return (op == 4'd0) || (op == 4'd1) || (op == 4'd2) || (op == 4'd4) ||
               (op == 4'd5) || (op == 4'd6) || (op == 4'd7);
    endfunction

    function automatic logic [15:0] model_alu(input logic [15:0] ins);
        logic [15:0] a, b, im;
        a  = m_r[ins[11:9]];
        b  = m_r[ins[8:6]];
        im = sx(ins[5:0]);
        case (ins[15:12])
            4'd0: case (ins[2:0])
                3'd0: return a + b;
                3'd1: return a - b;
                3'd2: return a & b;
                3'd3: return a | b;
                3'd4: return a ^ b;
                3'd5: return ($signed(a) < $signed(b)) ? 16'd1 : 16'd0;
                3'd6: return a << b[3:0];
                default: return a >> b[3:0];
            endcase
            4'd1, 4'd4, 4'd5: return a + im;
            4'd2: return ($signed(a) < $signed(im)) ? 16'd1 : 16'd0;
            4'd6, 4'd7: return a - b;
            default: return 16'h0000;
        endcase
    endfunction

    task automatic model_reset();
        m_pc = '0;
        for (int i = 0; i < 8; i++) m_r[i] = '0;
        for (int i = 0; i < 64; i++) m_mem[i] = '0;
    endtask

    task automatic model_step();
        logic [15:0] ins, res, nxt, im, a, b;
        logic [2:0]  rs, rt, rd;
        ins = rom_at(m_pc);
        res = model_alu(ins);
        rs  = ins[11:9];
        rt  = ins[8:6];
        rd  = ins[5:3];
        a   = m_r[rs];
        b   = m_r[rt];
        im  = sx(ins[5:0]);
        nxt = m_pc + 16'd1;
        case (ins[15:12])
            4'd0: if (rd != 0) m_r[rd] = res;
            4'd1, 4'd2: if (rt != 0) m_r[rt] = res;
            4'd4: if (rt != 0) m_r[rt] = m_mem[res[5:0]];
            4'd5: m_mem[res[5:0]] = b;
            4'd6: if (a == b) nxt = m_pc + 16'd1 + im;
            4'd7: if (a != b) nxt = m_pc + 16'd1 + im;
            4'd8: nxt = {m_pc[15:12], ins[11:0]};
            4'd9: begin
                m_r[7] = m_pc + 16'd1;
                nxt    = {m_pc[15:12], ins[11:0]};
            end
            default: ;
        endcase
        m_pc = nxt;
    endtask

    // ------------------------------ tests -------------------------------
    task automatic test_reset();
        reset = 1'b0;
        #100;
        vectors++;
        if (pc_out !== 16'h0000) begin
            miscompares++;
            $display("FAIL reset_pc: got %h want 0000", pc_out);
        end
        vectors++;
        if (instruction !== 16'h1045) begin
            miscompares++;
            $display("FAIL reset_instr: got %h want 1045", instruction);
        end
        vectors++;
        if ({obs_if.r1, obs_if.r2, obs_if.r3} !== 48'h0) begin
            miscompares++;
            $display("FAIL reset_regs: got %h %h %h want 0 0 0",
                     obs_if.r1, obs_if.r2, obs_if.r3);
        end
    endtask

    // Expected {pc, r1, r2, r3} after each edge of the default program
    localparam logic [63:0] PROG_EXP [10] = '{
        {16'd1, 16'd5, 16'd0, 16'd0},
        {16'd2, 16'd5, 16'd3, 16'd0},
        {16'd3, 16'd5, 16'd3, 16'd8},
        {16'd4, 16'd5, 16'd3, 16'd2},
        {16'd5, 16'd5, 16'd3, 16'd2},
        {16'd6, 16'd5, 16'd2, 16'd2},
        {16'd8, 16'd5, 16'd2, 16'd2},
        {16'd8, 16'd5, 16'd2, 16'd2},
        {16'd8, 16'd5, 16'd2, 16'd2},
        {16'd8, 16'd5, 16'd2, 16'd2}
    };

    task automatic test_program();
        logic [63:0] obs;
        @(negedge clk);
        reset = 1'b1;
        for (int e = 0; e < 10; e++) begin
            @(posedge clk);
            @(negedge clk);
            obs = {pc_out, obs_if.r1, obs_if.r2, obs_if.r3};
            vectors++;
            if (obs !== PROG_EXP[e]) begin
                miscompares++;
                $display("FAIL program_edge%0d: got pc/r1/r2/r3 %h want %h",
                         e + 1, obs, PROG_EXP[e]);
            end
            if (e == 1) begin
                vectors++;
                if (alu_result !== 16'd8) begin
                    miscompares++;
                    $display("FAIL alu_add_pc2: got %h want 0008", alu_result);
                end
            end
            if (e == 5) begin
                vectors++;
                if (alu_result !== 16'd0) begin
                    miscompares++;
                    $display("FAIL alu_beq_pc6: got %h want 0000", alu_result);
                end
            end
        end
    endtask

    // Random run lengths interrupted by resets at random points in the cycle
    task automatic test_random_resets();
        logic [79:0] obs, exp;
        int unsigned n;
        reset = 1'b0;
        model_reset();
        @(negedge clk);
        reset = 1'b1;
        for (int it = 0; it < 8; it++) begin
            n = $urandom_range(1, 14);
            for (int unsigned c = 0; c < n; c++) begin
                @(posedge clk);
                model_step();
                @(negedge clk);
                obs = {pc_out, instruction, obs_if.r1, obs_if.r2, obs_if.r3};
                exp = {m_pc, rom_at(m_pc), m_r[1], m_r[2], m_r[3]};
                vectors++;
                if (obs !== exp) begin
                    miscompares++;
                    $display("FAIL run_it%0d_c%0d: got %h want %h", it, c, obs, exp);
                end
                if (alu_defined(exp[63:60])) begin
                    vectors++;
                    if (alu_result !== model_alu(exp[63:48])) begin
                        miscompares++;
                        $display("FAIL run_alu_it%0d_c%0d: got %h want %h",
                                 it, c, alu_result, model_alu(exp[63:48]));
                    end
                end
            end
            @(posedge clk);
            model_step();
            #($urandom_range(1, 8));
            reset = 1'b0;
            #1;
            model_reset();
            obs = {pc_out, instruction, obs_if.r1, obs_if.r2, obs_if.r3};
            exp = {16'h0000, 16'h1045, 48'h0};
            vectors++;
            if (obs !== exp) begin
                miscompares++;
                $display("FAIL async_reset_it%0d: got %h want %h", it, obs, exp);
            end
            repeat ($urandom_range(1, 3)) @(posedge clk);
            @(negedge clk);
            vectors++;
            if (pc_out !== 16'h0000) begin
                miscompares++;
                $display("FAIL reset_hold_it%0d: got pc %h want 0000", it, pc_out);
            end
            reset = 1'b1;
        end
    endtask

    // Run into the final j 8 loop and check it holds
    task automatic test_jump_hold();
        logic [63:0] obs;
        repeat (12) begin
            @(posedge clk);
            model_step();
        end
        for (int c = 0; c < 20; c++) begin
            @(posedge clk);
            model_step();
            @(negedge clk);
            obs = {pc_out, obs_if.r1, obs_if.r2, obs_if.r3};
            vectors++;
            if (obs !== {16'd8, 16'd5, 16'd2, 16'd2} || m_pc !== 16'd8) begin
                miscompares++;
                $display("FAIL jump_hold_%0d: got pc/r1/r2/r3 %h want 0008000500020002 (model pc %h)",
                         c, obs, m_pc);
            end
        end
    endtask

    initial begin
        test_reset();
        test_program();
        test_random_resets();
        test_jump_hold();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
